// File: rtl/usb_dfifo_arbiter.sv
// ---------------------------------------------------------------------------
// usb_dfifo_arbiter
//
// Shares the single-port USB data-FIFO SRAM between three users:
//   1. the OTG controller's native dfifo port (absolute priority, no waits),
//   2. an auxiliary valid/ready port (debug readback / host inspection),
//   3. an internal clear engine that zero-fills the whole array.
//
// Ports (aclk domain, aresetn asynchronous active-low):
//   c_ce_n/c_we_n/c_addr/c_wdata   controller request, passed straight through
//   c_rdata                        controller read data (= m_rdata)
//   a_req_valid/ready/we/addr/wdata  aux request handshake
//   a_rsp_valid/a_rsp_data         aux read response, one cycle after handshake
//   a_wait_max                     longest aux stall seen, saturating
//   clr_start/clr_busy/clr_done    clear engine control and status
//   m_ce_n/m_we_n/m_addr/m_wdata   SRAM macro inputs (combinational)
//   m_rdata                        SRAM macro output, 1-cycle read latency
// ---------------------------------------------------------------------------
module usb_dfifo_arbiter #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 35,
   parameter int WAIT_WIDTH = 16
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  c_ce_n,
   input  logic                  c_we_n,
   input  logic [ADDR_WIDTH-1:0] c_addr,
   input  logic [DATA_WIDTH-1:0] c_wdata,
   output logic [DATA_WIDTH-1:0] c_rdata,
   input  logic                  a_req_valid,
   output logic                  a_req_ready,
   input  logic                  a_req_we,
   input  logic [ADDR_WIDTH-1:0] a_req_addr,
   input  logic [DATA_WIDTH-1:0] a_req_wdata,
   output logic                  a_rsp_valid,
   output logic [DATA_WIDTH-1:0] a_rsp_data,
   output logic [WAIT_WIDTH-1:0] a_wait_max,
   input  logic                  clr_start,
   output logic                  clr_busy,
   output logic                  clr_done,
   output logic                  m_ce_n,
   output logic                  m_we_n,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [DATA_WIDTH-1:0] m_wdata,
   input  logic [DATA_WIDTH-1:0] m_rdata
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
   localparam logic [WAIT_WIDTH-1:0] WAIT_SAT  = '1;

   logic [1:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_clr_ptr;
   logic                  r_rsp_valid;
   logic [WAIT_WIDTH-1:0] r_wait_cnt;
   logic [WAIT_WIDTH-1:0] r_wait_max;

   logic w_clr_busy;
   logic w_clr_grant;
   logic w_aux_ready;
   logic w_aux_hs;

   assign w_clr_busy  = (r_state == S_CLEAR);
   // The clear engine only gets the SRAM in cycles the controller leaves idle.
   assign w_clr_grant = w_clr_busy & c_ce_n;
   assign w_aux_ready = c_ce_n & ~w_clr_busy;
   assign w_aux_hs    = a_req_valid & w_aux_ready;

   assign a_req_ready = w_aux_ready;
   assign clr_busy    = w_clr_busy;
   assign clr_done    = (r_state == S_DONE);
   assign a_rsp_valid = r_rsp_valid;
   assign a_wait_max  = r_wait_max;

   // Both read-data outputs are pure pass-through: each consumer only looks at
   // m_rdata in the cycle after its own read, so sharing the bus is safe.
   assign c_rdata    = m_rdata;
   assign a_rsp_data = m_rdata;

   // SRAM port mux: controller > clear engine > aux.
   always_comb begin
      m_ce_n  = 1'b1;
      m_we_n  = 1'b1;
      m_addr  = a_req_addr;
      m_wdata = a_req_wdata;
      if (!c_ce_n) begin
         m_ce_n  = 1'b0;
         m_we_n  = c_we_n;
         m_addr  = c_addr;
         m_wdata = c_wdata;
      end else if (w_clr_busy) begin
         m_ce_n  = 1'b0;
         m_we_n  = 1'b0;
         m_addr  = r_clr_ptr;
         m_wdata = '0;
      end else if (w_aux_hs) begin
         m_ce_n  = 1'b0;
         m_we_n  = ~a_req_we;
      end
   end

   // Clear engine. clr_start is only honoured in IDLE; an aux request accepted
   // in that same cycle is already on the SRAM bus, so it completes first.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state   <= S_IDLE;
         r_clr_ptr <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (clr_start) begin
                  r_state   <= S_CLEAR;
                  r_clr_ptr <= '0;
               end
            end
            S_CLEAR: begin
               // Pointer advances only on granted writes, so controller
               // cycles pause the sweep without skipping addresses.
               if (w_clr_grant) begin
                  r_clr_ptr <= r_clr_ptr + 1'b1;
                  if (r_clr_ptr == LAST_ADDR) begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Aux read response follows the SRAM's one-cycle read latency.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rsp_valid <= 1'b0;
      end else begin
         r_rsp_valid <= w_aux_hs & ~a_req_we;
      end
   end

   // Stall statistic: count cycles an aux request is held off, fold the count
   // into the running maximum on acceptance. Both are saturating by width.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wait_cnt <= '0;
         r_wait_max <= '0;
      end else begin
         if (w_aux_hs) begin
            if (r_wait_cnt > r_wait_max) begin
               r_wait_max <= r_wait_cnt;
            end
            r_wait_cnt <= '0;
         end else if (a_req_valid && !w_aux_ready && (r_wait_cnt != WAIT_SAT)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_usb_dfifo_arbiter.sv
// ---------------------------------------------------------------------------
// tb_usb_dfifo_arbiter
//
// Self-checking bench for usb_dfifo_arbiter with a behavioural 2048 x 35 SRAM
// (1-cycle read latency) attached to the m_* port. Aux read expectations come
// from a bench-side reference image and are queued when the read is issued,
// then popped and compared when a_rsp_valid appears.
// ---------------------------------------------------------------------------
module tb_usb_dfifo_arbiter;

   localparam int AW    = 11;
   localparam int DW    = 35;
   localparam int WW    = 16;
   localparam int DEPTH = 1 << AW;

   logic          aclk;
   logic          aresetn;
   logic          c_ce_n;
   logic          c_we_n;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata;
   logic [DW-1:0] c_rdata;
   logic          a_req_valid;
   logic          a_req_ready;
   logic          a_req_we;
   logic [AW-1:0] a_req_addr;
   logic [DW-1:0] a_req_wdata;
   logic          a_rsp_valid;
   logic [DW-1:0] a_rsp_data;
   logic [WW-1:0] a_wait_max;
   logic          clr_start;
   logic          clr_busy;
   logic          clr_done;
   logic          m_ce_n;
   logic          m_we_n;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;

   usb_dfifo_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .WAIT_WIDTH (WW)
   ) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .c_ce_n      (c_ce_n),
      .c_we_n      (c_we_n),
      .c_addr      (c_addr),
      .c_wdata     (c_wdata),
      .c_rdata     (c_rdata),
      .a_req_valid (a_req_valid),
      .a_req_ready (a_req_ready),
      .a_req_we    (a_req_we),
      .a_req_addr  (a_req_addr),
      .a_req_wdata (a_req_wdata),
      .a_rsp_valid (a_rsp_valid),
      .a_rsp_data  (a_rsp_data),
      .a_wait_max  (a_wait_max),
      .clr_start   (clr_start),
      .clr_busy    (clr_busy),
      .clr_done    (clr_done),
      .m_ce_n      (m_ce_n),
      .m_we_n      (m_we_n),
      .m_addr      (m_addr),
      .m_wdata     (m_wdata),
      .m_rdata     (m_rdata)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Behavioural single-port SRAM.
   logic [DW-1:0] sram [DEPTH];
   always @(posedge aclk) begin
      if (!m_ce_n) begin
         if (!m_we_n) sram[m_addr] <= m_wdata;
         else         m_rdata      <= sram[m_addr];
      end
   end

   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] exp_q [$];
   int n_vec = 0;
   int n_err = 0;
   int busy_mon = 0;
   int done_mon = 0;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Response scoreboard.
   always @(negedge aclk) begin
      if (aresetn && a_rsp_valid) begin
         if (exp_q.size() == 0) begin
            check_val("rsp_unexpected", 64'(1), 64'(0));
         end else begin
            check_val("rsp_data", 64'(a_rsp_data), 64'(exp_q.pop_front()));
         end
      end
   end

   always @(negedge aclk) begin
      if (clr_busy) busy_mon++;
      if (clr_done) done_mon++;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Stimulus is driven 1 time unit after the falling edge.
   task automatic tick();
      @(posedge aclk);
      @(negedge aclk);
      #1;
   endtask

   task automatic aux_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int budget, output int waited);
      a_req_valid = 1'b1;
      a_req_we    = we;
      a_req_addr  = addr;
      a_req_wdata = data;
      waited      = 0;
      #1;
      while (!a_req_ready && waited < budget) begin
         tick();
         waited++;
      end
      if (!a_req_ready) begin
         check_val("aux_accept_timeout", 64'(0), 64'(1));
      end else begin
         if (we) ref_mem[addr] = data;
         else    exp_q.push_back(ref_mem[addr]);
         tick();
      end
      a_req_valid = 1'b0;
   endtask

   task automatic ctl_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      c_ce_n  = 1'b0;
      c_we_n  = 1'b0;
      c_addr  = addr;
      c_wdata = data;
      ref_mem[addr] = data;
      tick();
      c_ce_n = 1'b1;
      c_we_n = 1'b1;
   endtask

   task automatic fill_all(input logic [DW-1:0] data);
      for (int i = 0; i < DEPTH; i++) ctl_write(AW'(i), data);
   endtask

   task automatic read_all();
      int w;
      for (int i = 0; i < DEPTH; i++) aux_req(1'b0, AW'(i), '0, 4, w);
   endtask

   task automatic drain();
      int g = 0;
      while (exp_q.size() != 0 && g < 10) begin
         tick();
         g++;
      end
      check_val("rsp_drain", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic wait_done(input int budget);
      int g = 0;
      int d0 = done_mon;
      while (done_mon == d0 && g < budget) begin
         tick();
         g++;
      end
      check_val("clr_done_seen", 64'(done_mon - d0), 64'(1));
      tick();
   endtask

   int w;
   int b0;
   int d0;
   int g;

   initial begin
      aresetn     = 1'b0;
      c_ce_n      = 1'b1;
      c_we_n      = 1'b1;
      c_addr      = '0;
      c_wdata     = '0;
      a_req_valid = 1'b0;
      a_req_we    = 1'b0;
      a_req_addr  = '0;
      a_req_wdata = '0;
      clr_start   = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

      // ---- reset state ----
      #12;
      check_val("rst_clr_busy",  64'(clr_busy), 64'(0));
      check_val("rst_clr_done",  64'(clr_done), 64'(0));
      check_val("rst_rsp_valid", 64'(a_rsp_valid), 64'(0));
      check_val("rst_wait_max",  64'(a_wait_max), 64'(0));
      check_val("rst_m_ce_n",    64'(m_ce_n), 64'(1));
      check_val("rst_m_we_n",    64'(m_we_n), 64'(1));
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      check_val("idle_ready", 64'(a_req_ready), 64'(1));

      // Give every location a defined value before any aux read.
      fill_all(35'h0_0000_0000);

      // ---- aux write then back-to-back aux read ----
      a_req_valid = 1'b1;
      a_req_we    = 1'b1;
      a_req_addr  = 11'h155;
      a_req_wdata = 35'h7_0000_0001;
      #1;
      check_val("aux_wr_m_ce_n",  64'(m_ce_n), 64'(0));
      check_val("aux_wr_m_we_n",  64'(m_we_n), 64'(0));
      check_val("aux_wr_m_addr",  64'(m_addr), 64'(11'h155));
      check_val("aux_wr_m_wdata", 64'(m_wdata), 64'(35'h7_0000_0001));
      aux_req(1'b1, 11'h155, 35'h7_0000_0001, 0, w);
      check_val("aux_wr_wait", 64'(w), 64'(0));
      aux_req(1'b0, 11'h155, '0, 0, w);
      check_val("aux_rd_wait", 64'(w), 64'(0));
      check_val("aux_rd_rsp_valid", 64'(a_rsp_valid), 64'(1));
      drain();

      // ---- controller reads block aux for 10 cycles ----
      a_req_valid = 1'b1;
      a_req_we    = 1'b0;
      a_req_addr  = 11'h155;
      for (int k = 0; k < 10; k++) begin
         c_ce_n = 1'b0;
         c_we_n = 1'b1;
         c_addr = 11'h155;
         #1;
         check_val("ctl_blocks_aux", 64'(a_req_ready), 64'(0));
         check_val("ctl_m_addr", 64'(m_addr), 64'(11'h155));
         if (k == 1) check_val("ctl_rdata", 64'(c_rdata), 64'(35'h7_0000_0001));
         tick();
      end
      c_ce_n = 1'b1;
      #1;
      check_val("aux_ready_after_ctl", 64'(a_req_ready), 64'(1));
      exp_q.push_back(ref_mem[11'h155]);
      tick();
      a_req_valid = 1'b0;
      check_val("wait_max_10", 64'(a_wait_max), 64'(10));
      drain();

      // ---- full clear on an idle bus ----
      fill_all(35'h0_0000_1234);
      b0 = busy_mon;
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      check_val("clr_busy_start", 64'(clr_busy), 64'(1));
      check_val("clr_m_ce_n",  64'(m_ce_n), 64'(0));
      check_val("clr_m_we_n",  64'(m_we_n), 64'(0));
      check_val("clr_m_addr0", 64'(m_addr), 64'(0));
      check_val("clr_m_wdata", 64'(m_wdata), 64'(0));
      check_val("clr_blocks_aux", 64'(a_req_ready), 64'(0));
      d0 = done_mon;
      wait_done(3000);
      check_val("clr_busy_cycles", 64'(busy_mon - b0), 64'(2048));
      check_val("clr_done_pulses", 64'(done_mon - d0), 64'(1));
      check_val("clr_busy_end", 64'(clr_busy), 64'(0));
      read_all();
      drain();

      // ---- clear with 5 controller writes in the middle ----
      fill_all(35'h0_0000_1234);
      b0 = busy_mon;
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      g = 0;
      while ((busy_mon - b0) < 500 && g < 3000) begin
         tick();
         g++;
      end
      for (int i = 0; i < 5; i++) begin
         c_ce_n  = 1'b0;
         c_we_n  = 1'b0;
         c_addr  = AW'(10 + i);
         c_wdata = 35'h0_0005_A5A0 + 35'(i);
         ref_mem[10 + i] = 35'h0_0005_A5A0 + 35'(i);
         #1;
         check_val("midclr_ctl_addr", 64'(m_addr), 64'(10 + i));
         tick();
      end
      c_ce_n = 1'b1;
      c_we_n = 1'b1;
      wait_done(3000);
      check_val("midclr_busy_cycles", 64'(busy_mon - b0), 64'(2053));
      read_all();
      drain();

      // ---- clr_start and aux read in the same idle cycle ----
      b0 = busy_mon;
      d0 = done_mon;
      clr_start = 1'b1;
      aux_req(1'b0, 11'd12, '0, 0, w);
      clr_start = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      check_val("same_cycle_aux_wait", 64'(w), 64'(0));
      check_val("same_cycle_rsp_valid", 64'(a_rsp_valid), 64'(1));
      check_val("same_cycle_clr_busy", 64'(clr_busy), 64'(1));
      aux_req(1'b0, 11'd12, '0, 3000, w);
      check_val("aux_blocked_cycles", 64'(w), 64'(2048));
      check_val("blocked_done_pulses", 64'(done_mon - d0), 64'(1));
      check_val("blocked_busy_cycles", 64'(busy_mon - b0), 64'(2048));
      check_val("wait_max_2048", 64'(a_wait_max), 64'(2048));
      drain();

      // ---- reset drops a pending aux response ----
      aux_req(1'b0, 11'h155, '0, 0, w);
      check_val("pre_rst_rsp_valid", 64'(a_rsp_valid), 64'(1));
      #1;
      aresetn = 1'b0;
      #1;
      check_val("rst_drops_rsp", 64'(a_rsp_valid), 64'(0));
      check_val("rst_clears_wait_max", 64'(a_wait_max), 64'(0));
      exp_q.delete();
      @(negedge aclk);
      aresetn = 1'b1;
      #1;

      // ---- reset at clear step 100 ----
      a_req_valid = 1'b1;
      a_req_we    = 1'b0;
      a_req_addr  = 11'd3;
      for (int k = 0; k < 3; k++) begin
         c_ce_n = 1'b0;
         c_we_n = 1'b1;
         c_addr = 11'd3;
         tick();
      end
      c_ce_n = 1'b1;
      exp_q.push_back(ref_mem[3]);
      tick();
      a_req_valid = 1'b0;
      check_val("wait_max_3", 64'(a_wait_max), 64'(3));
      drain();
      b0 = busy_mon;
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      g = 0;
      while ((busy_mon - b0) < 100 && g < 3000) begin
         tick();
         g++;
      end
      check_val("abort_busy_before", 64'(clr_busy), 64'(1));
      d0 = done_mon;
      aresetn = 1'b0;
      #1;
      check_val("abort_clr_busy",  64'(clr_busy), 64'(0));
      check_val("abort_rsp_valid", 64'(a_rsp_valid), 64'(0));
      check_val("abort_wait_max",  64'(a_wait_max), 64'(0));
      check_val("abort_clr_done",  64'(clr_done), 64'(0));
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      b0 = busy_mon;
      for (int k = 0; k < 2100; k++) tick();
      check_val("abort_no_done", 64'(done_mon - d0), 64'(0));
      check_val("abort_no_busy", 64'(busy_mon - b0), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
